food_event_gen: RTL and testbench
=================================

FOOD_EVENT_GEN -- requirements
Module: food_event_gen

Interface
REQ-001 SHALL have parameter GRID_W, default 40, meaning playfield width in cells (legal x = 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 30, meaning playfield height in cells (legal y = 0..GRID_H-1).
REQ-003 SHALL have parameter LFSR_SEED, default 12'hACE, meaning the nonzero LFSR value loaded at reset.
REQ-004 clk  input  1  single clock; the only clock; all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 step  input  1  one-cycle pulse: snake has advanced one cell.
REQ-007 head_x, head_y  input  6 each  head cell after the current step; valid while step=1.
REQ-008 occ_req  output  1  occupancy query request to the body store.
REQ-009 occ_x, occ_y  output  6 each  candidate cell under query; stable while occ_req=1.
REQ-010 occ_ack  input  1  one-cycle pulse: query answered.
REQ-011 occ_hit  input  1  candidate lies on snake body; valid with occ_ack.
REQ-012 food_x, food_y  output  6 each  current food cell.
REQ-013 food_valid  output  1  food placed and eatable.
REQ-014 increment  output  1  registered one-clk-wide pulse per food eaten; drives the score counter's increment input.

Function
REQ-015 FSM states SHALL be GEN, QUERY, ACTIVE.
REQ-016 GEN: advance 12-bit Fibonacci LFSR (taps 12,11,10,4) once per clk; candidate x = lfsr[5:0], y = lfsr[11:6].
- Candidate with x>=GRID_W or y>=GRID_H: rejected, stay in GEN.
- Otherwise: latch into occ_x/occ_y, assert occ_req, go to QUERY.
REQ-017 QUERY: occ_req held high until the clk sampling occ_ack=1.
- occ_hit=1: drop occ_req, go to GEN.
- occ_hit=0: food_x/food_y <= candidate, food_valid <= 1, drop occ_req, go to ACTIVE.
REQ-018 ACTIVE: on step=1 with head_x==food_x and head_y==food_y: increment=1 for exactly the next cycle, food_valid <= 0, go to GEN.
REQ-019 step with no match, or step in GEN/QUERY, SHALL have no effect; eats are never queued.
REQ-020 increment SHALL come from a flop (no combinational path) and SHALL never be high two consecutive cycles.
REQ-021 Eat latency: increment high in the cycle after the matching step cycle.
REQ-022 occ_ack outside QUERY SHALL be ignored.
REQ-023 LFSR SHALL advance only in GEN; it never reaches all-zeros.

Reset
REQ-024 rst=0 SHALL force state=GEN, lfsr=LFSR_SEED, food_x=food_y=0, food_valid=0, increment=0, occ_req=0, occ_x=occ_y=0, asynchronously.
REQ-025 Reset mid-QUERY SHALL drop occ_req immediately; a later occ_ack SHALL be ignored.

Configuration
REQ-026 Macro FOOD_TIMEOUT_EN defined: 8-bit counter of steps in ACTIVE.
- Cleared on entry to ACTIVE.
- On reaching 200 steps without an eat: food_valid <= 0, go to GEN, no increment.
REQ-027 FOOD_TIMEOUT_EN undefined: no counter; food stays until eaten.

Structure
REQ-028 Shared package SHALL hold the state enum (GEN/QUERY/ACTIVE), coordinate width constant COORD_W=6, LFSR width 12, and timeout limit 200.
REQ-029 LFSR SHALL be a sub-module lfsr12 (inputs clk, rst, en; output 12-bit value; seed parameter).
- The FSM/compare logic stays in food_event_gen.

Verification
REQ-030 Reset release, occ_ack with occ_hit=0 at first query -> food_valid=1, food_x/y equal first in-range LFSR candidate from seed 12'hACE.
REQ-031 ACTIVE, food (5,7), step with head (5,7) -> increment=1 one cycle later for exactly one cycle, food_valid=0, occ_req re-asserted after in-range candidate.
REQ-032 Query answered occ_hit=1 three times then 0 -> four occ_req handshakes, food_valid rises only after the fourth.
REQ-033 Step with head (5,8) vs food (5,7), and steps during GEN -> increment never asserts.
REQ-034 rst pulsed low while occ_req=1, occ_ack arriving afterwards -> occ_req=0 immediately, stray ack ignored, FSM in GEN.
REQ-035 With FOOD_TIMEOUT_EN: 200 non-matching steps -> food_valid falls, increment stays 0; without it, food_valid stays 1.

Source files
------------

// File: rtl/food_event_gen_pkg.sv
// Shared definitions for the food event generator: FSM states, coordinate and
// LFSR widths, the food timeout limit and the LFSR next-value function.
package food_event_gen_pkg;

    localparam int COORD_W       = 6;
    localparam int LFSR_W        = 12;
    localparam int TIMEOUT_LIMIT = 200;
    localparam int TIMEOUT_W     = 8;

    typedef enum logic [1:0] {
        GEN    = 2'd0,
        QUERY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 12,11,10,4 (tap n is bit n-1), shifting towards the MSB.
    // The feedback includes the MSB, so the map is invertible and a nonzero
    // value can never step to all-zeros.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[11] ^ v[10] ^ v[9] ^ v[3]};
    endfunction

endpackage

// File: rtl/food_event_gen_lfsr12.sv
// 12-bit pseudo-random source for food placement. Advances only while en=1.
module lfsr12
    import food_event_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 12'hACE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next value: step the shift register only when enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // State register, seeded asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/food_event_gen.sv
// Food event generator: picks a random free cell for the food, waits for the
// snake head to land on it, then pulses increment for the score counter.
// Optional build macro FOOD_TIMEOUT_EN: food that goes uneaten for 200 steps is
// withdrawn and a new cell is chosen (no increment).
//
// Occupancy handshake: occ_req rises together with a new occ_x/occ_y and both
// stay stable until the first clock on which occ_ack=1 is sampled; occ_hit is
// only looked at on that clock, and occ_req drops on the following cycle.
// occ_ack seen while no query is outstanding is ignored.
module food_event_gen
    import food_event_gen_pkg::*;
#(
    parameter int                GRID_W    = 40,
    parameter int                GRID_H    = 30,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 12'hACE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               increment,
    output logic [1:0]         state_o
);

    // One extra bit so a grid dimension of 64 still compares correctly.
    localparam logic [COORD_W:0] GRID_W_L = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0] GRID_H_L = (COORD_W+1)'(GRID_H);

    state_t             state_q;
    logic               occ_req_q;
    logic [COORD_W-1:0] occ_x_q;
    logic [COORD_W-1:0] occ_y_q;
    logic [COORD_W-1:0] food_x_q;
    logic [COORD_W-1:0] food_y_q;
    logic               food_valid_q;
    logic               increment_q;

    logic [LFSR_W-1:0]  lfsr_val;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic               cand_ok;
    logic               head_match;
    logic               timeout_hit;

    lfsr12 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == GEN),
        .value (lfsr_val)
    );

    assign cand_x     = lfsr_val[COORD_W-1:0];
    assign cand_y     = lfsr_val[LFSR_W-1:COORD_W];
    assign cand_ok    = ({1'b0, cand_x} < GRID_W_L) && ({1'b0, cand_y} < GRID_H_L);
    assign head_match = step && (head_x == food_x_q) && (head_y == food_y_q);

`ifdef FOOD_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_LIMIT - 1);

    logic [TIMEOUT_W-1:0] to_cnt_q;

    assign timeout_hit = (state_q == ACTIVE) && step && !head_match
                         && (to_cnt_q == TIMEOUT_LAST);

    // Count non-eating steps of the current food; held at zero until ACTIVE is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q != ACTIVE) begin
            to_cnt_q <= '0;
        end else if (step && !head_match && !timeout_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Placement / query / eat state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= GEN;
            occ_req_q    <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            increment_q  <= 1'b0;
        end else begin
            increment_q <= 1'b0;
            case (state_q)
                GEN: begin
                    if (cand_ok) begin
                        occ_x_q   <= cand_x;
                        occ_y_q   <= cand_y;
                        occ_req_q <= 1'b1;
                        state_q   <= QUERY;
                    end
                end
                QUERY: begin
                    if (occ_ack) begin
                        occ_req_q <= 1'b0;
                        if (occ_hit) begin
                            state_q <= GEN;
                        end else begin
                            food_x_q     <= occ_x_q;
                            food_y_q     <= occ_y_q;
                            food_valid_q <= 1'b1;
                            state_q      <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (head_match) begin
                        increment_q  <= 1'b1;
                        food_valid_q <= 1'b0;
                        state_q      <= GEN;
                    end else if (timeout_hit) begin
                        food_valid_q <= 1'b0;
                        state_q      <= GEN;
                    end
                end
                default: begin
                    state_q <= GEN;
                end
            endcase
        end
    end

    assign occ_req    = occ_req_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign increment  = increment_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_food_event_gen.sv
// Bench for food_event_gen: acts as the body store and the snake, predicts the
// food cells from an independent model of the placement LFSR.
module tb_food_event_gen;

    localparam logic [11:0] SEED = 12'hACE;
    localparam int GW = 40;
    localparam int GH = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic [5:0] head_x = '0;
    logic [5:0] head_y = '0;
    logic       occ_req;
    logic [5:0] occ_x;
    logic [5:0] occ_y;
    logic       occ_ack = 1'b0;
    logic       occ_hit = 1'b0;
    logic [5:0] food_x;
    logic [5:0] food_y;
    logic       food_valid;
    logic       increment;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    food_event_gen dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .head_x     (head_x),
        .head_y     (head_y),
        .occ_req    (occ_req),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_ack    (occ_ack),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .increment  (increment),
        .state_o    (state_o)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard of predicted candidate cells, {y, x}.
    logic [11:0] exp_q[$];
    logic [11:0] lfsr_m;

    // Monitors: occ_req rising edges, increment pulses, back-to-back increments.
    int   req_rises = 0;
    int   inc_pulses = 0;
    int   inc_double = 0;
    logic inc_p = 1'b0;

    always @(posedge occ_req) req_rises = req_rises + 1;

    always @(posedge clk) begin
        inc_p <= increment;
        if (increment === 1'b1) inc_pulses <= inc_pulses + 1;
        if (increment === 1'b1 && inc_p === 1'b1) inc_double <= inc_double + 1;
    end

    typedef struct {
        int n_hits;
        int ack_dly;
        int n_wrong;
        int exp_reqs;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Taps 12,11,10,4 of a shift-left Fibonacci register (tap n = bit n-1).
    function automatic logic [11:0] model_step(input logic [11:0] v);
        logic fb;
        fb = v[12-1] ^ v[11-1] ^ v[10-1] ^ v[4-1];
        return {v[10:0], fb};
    endfunction

    // Next in-range candidate as seen by the DUT, walking the model forward.
    task automatic next_candidate(output logic [11:0] c);
        c = '0;
        for (int i = 0; i < 4096; i++) begin
            c = lfsr_m;
            lfsr_m = model_step(lfsr_m);
            if (int'(c[5:0]) < GW && int'(c[11:6]) < GH) break;
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 4000; i++) begin
            if (occ_req === 1'b1) break;
            tick();
        end
        chk("occ_req_arrives", occ_req, 1);
    endtask

    // Answer one occupancy query after dly cycles with the given hit flag.
    task automatic serve(input bit hit, input int dly);
        logic [11:0] e;
        next_candidate(e);
        exp_q.push_back(e);
        wait_req();
        e = exp_q.pop_front();
        chk("occ_xy", {occ_y, occ_x}, e);
        chk("food_valid_during_query", food_valid, 0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("occ_req_held", occ_req, 1);
            chk("occ_xy_stable", {occ_y, occ_x}, e);
        end
        occ_ack = 1'b1;
        occ_hit = hit;
        tick();
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        chk("occ_req_dropped", occ_req, 0);
        if (hit) begin
            chk("food_valid_after_hit", food_valid, 0);
        end else begin
            chk("food_valid_set", food_valid, 1);
            chk("food_xy", {food_y, food_x}, e);
            chk("state_active", state_o, 2);
        end
    endtask

    // One-cycle step pulse; checks increment on the following cycle and after.
    task automatic do_step(input logic [5:0] hx, input logic [5:0] hy, input bit exp_inc);
        step = 1'b1;
        head_x = hx;
        head_y = hy;
        tick();
        step = 1'b0;
        chk("increment", increment, exp_inc);
        if (exp_inc) chk("food_valid_after_eat", food_valid, 0);
        tick();
        chk("increment_single_cycle", increment, 0);
    endtask

    initial begin
        logic [5:0]  fx;
        logic [5:0]  fy;
        logic [11:0] e;
        int          base;
        int          kind;

        vecs[0] = '{3, 1, 2, 4};
        vecs[1] = '{0, 0, 1, 1};
        vecs[2] = '{1, 2, 0, 2};
        vecs[3] = '{2, 0, 3, 3};
        vecs[4] = '{0, 3, 0, 1};

        // Reset state.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_occ_req", occ_req, 0);
        chk("rst_occ_xy", {occ_y, occ_x}, 0);
        chk("rst_food_xy", {food_y, food_x}, 0);
        chk("rst_food_valid", food_valid, 0);
        chk("rst_increment", increment, 0);
        rst = 1'b1;
        lfsr_m = SEED;

        // First placement from the seed, accepted at once.
        serve(1'b0, 0);

        // Acks while ACTIVE must change nothing.
        fx = food_x;
        fy = food_y;
        for (int i = 0; i < 2; i++) begin
            occ_ack = 1'b1;
            occ_hit = (i == 1);
            tick();
            occ_ack = 1'b0;
            occ_hit = 1'b0;
            chk("stray_ack_food_valid", food_valid, 1);
            chk("stray_ack_food_xy", {food_y, food_x}, {fy, fx});
            chk("stray_ack_occ_req", occ_req, 0);
            chk("stray_ack_state", state_o, 2);
        end

        // Table: near misses, eat, step in GEN, then a placement with n_hits rejections.
        for (int v = 0; v < 5; v++) begin
            fx = food_x;
            fy = food_y;
            for (int w = 0; w < vecs[v].n_wrong; w++) begin
                kind = $urandom_range(0, 2);
                do_step((kind == 0) ? fx : (fx ^ 6'h01),
                        (kind == 1) ? fy : (fy ^ 6'h01), 1'b0);
                chk("food_valid_after_miss", food_valid, 1);
            end
            base = req_rises;
            do_step(fx, fy, 1'b1);
            do_step(fx, fy, 1'b0);
            for (int h = 0; h <= vecs[v].n_hits; h++) begin
                serve(h < vecs[v].n_hits, vecs[v].ack_dly);
            end
            chk("req_handshakes", req_rises - base, vecs[v].exp_reqs);
        end

        // Reset while a query is outstanding; a later ack must be ignored.
        fx = food_x;
        fy = food_y;
        do_step(fx, fy, 1'b1);
        next_candidate(e);
        wait_req();
        chk("pre_rst_occ_xy", {occ_y, occ_x}, e);
        rst = 1'b0;
        #1;
        chk("rst_mid_query_occ_req", occ_req, 0);
        chk("rst_mid_query_state", state_o, 0);
        chk("rst_mid_query_food_valid", food_valid, 0);
        tick();
        rst = 1'b1;
        occ_ack = 1'b1;
        occ_hit = 1'b0;
        tick();
        occ_ack = 1'b0;
        chk("late_ack_state", state_o, 0);
        chk("late_ack_food_valid", food_valid, 0);
        chk("late_ack_occ_req", occ_req, 0);
        exp_q.delete();
        lfsr_m = SEED;
        serve(1'b0, 1);

        // Long run of non-matching steps.
        fx = food_x;
        fy = food_y;
        base = inc_pulses;
        for (int i = 0; i < 199; i++) begin
            step = 1'b1;
            head_x = fx;
            head_y = fy ^ 6'h01;
            tick();
            step = 1'b0;
            tick();
        end
        chk("food_valid_after_199", food_valid, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
`ifdef FOOD_TIMEOUT_EN
        chk("food_valid_after_timeout", food_valid, 0);
`else
        chk("food_valid_after_200", food_valid, 1);
`endif
        chk("no_increment_on_misses", inc_pulses - base, 0);
        chk("increment_never_doubled", inc_double, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
